// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream boot loader driving the instruction-memory programming port
//
// Frame: SYNC_BYTE, CNT_LO, CNT_HI, N*STEP data bytes (little-endian words), CHK (XOR of data bytes).
// Ports:
//   clk, rst              - clock (rising edge), asynchronous active-high reset
//   in_valid, in_data     - incoming stream byte
//   in_ready              - loader accepts a byte this cycle
//   pgm, addr, data       - single-cycle instruction-memory write (word address, assembled word)
//   cpu_hold              - core held while a frame is in progress
//   done, err             - sticky status of the last frame
module prog_loader #(
  parameter int         INSTR_ADDR_WIDTH = 20,
  parameter int         STEP             = 4,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        pgm,
  output logic [INSTR_ADDR_WIDTH-1:0] addr,
  output logic [STEP*8-1:0]           data,
  output logic                        cpu_hold,
  output logic                        done,
  output logic                        err
);

  localparam int             DW        = STEP * 8;
  localparam int             IW        = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [IW-1:0]  LAST_IDX  = IW'(STEP - 1);
  localparam logic [32:0]    MAX_WORDS = 33'd1 << INSTR_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_L, S_CNT_H, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      cnt_lo;
  logic [7:0]      chk;
  logic [15:0]     remaining;
  logic [IW-1:0]   byte_idx;
  logic            accept;
  logic [15:0]     cnt_full;
  logic            cnt_over;
  logic [DW+7:0]   shift_in;

  assign accept   = in_valid && in_ready;
  assign cnt_full = {in_data, cnt_lo};
  assign cnt_over = {17'd0, cnt_full} > MAX_WORDS;
  // New byte enters at the top; after STEP bytes the first one sits in data[7:0].
  assign shift_in = {in_data, data};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && in_data == SYNC_BYTE) state_nxt = S_CNT_L;
      S_CNT_L: if (accept) state_nxt = S_CNT_H;
      S_CNT_H: if (accept) begin
        if (cnt_over)             state_nxt = S_ERR;
        else if (cnt_full == '0)  state_nxt = S_CHECK;
        else                      state_nxt = S_DATA;
      end
      S_DATA:  if (accept && byte_idx == LAST_IDX) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (remaining == 16'd1) ? S_CHECK : S_DATA;
      S_CHECK: if (accept) state_nxt = (in_data == chk) ? S_DONE : S_ERR;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    in_ready = 1'b0;
    pgm      = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        cpu_hold = 1'b0;
      end
      S_CNT_L, S_CNT_H, S_DATA, S_CHECK: in_ready = 1'b1;
      S_WRITE: pgm = 1'b1;
      default: ;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lo    <= '0;
      chk       <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      addr      <= '0;
      data      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept && in_data == SYNC_BYTE) begin
          done <= 1'b0;
          err  <= 1'b0;
        end
        S_CNT_L: if (accept) cnt_lo <= in_data;
        S_CNT_H: if (accept) begin
          remaining <= cnt_full;
          addr      <= '0;
          chk       <= '0;
          byte_idx  <= '0;
        end
        S_DATA: if (accept) begin
          data     <= shift_in[DW+7:8];
          chk      <= chk ^ in_data;
          byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
        end
        S_WRITE: begin
          remaining <= remaining - 16'd1;
          // Hold addr on the final word so a full-size load never wraps it.
          if (remaining != 16'd1) addr <= addr + 1'b1;
        end
        S_DONE: done <= 1'b1;
        S_ERR:  err  <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

  localparam int AW   = 5;
  localparam int STEP = 4;
  localparam int MAXN = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          pgm;
  logic [AW-1:0] addr;
  logic [31:0]   data;
  logic          cpu_hold;
  logic          done;
  logic          err;

  prog_loader #(
    .INSTR_ADDR_WIDTH(AW),
    .STEP(STEP),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .pgm(pgm),
    .addr(addr),
    .data(data),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0]   words[$];
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  int            rdy_in_write = 0;

  // Capture every write strobe seen by the instruction memory
  always @(negedge clk) begin
    if (pgm) begin
      got_addr.push_back(addr);
      got_data.push_back(data);
      if (in_ready) rdy_in_write++;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte, wait (bounded) for acceptance; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    int t;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    t = 0;
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  // Reference model: build the frame from words[], predict writes and status, then compare.
  task automatic run_frame(input string name, input int n, input logic [7:0] chk_xor, input int max_gap);
    logic [7:0]  c;
    logic [31:0] w;
    logic [15:0] n16;
    bit          ovf;
    bit          ok;
    int          nw;
    c   = 8'h00;
    n16 = 16'(n);
    ovf = (n > MAXN);
    got_addr.delete();
    got_data.delete();
    rdy_in_write = 0;
    send_byte(8'hA5, max_gap);
    check({name, ":hold_after_sync"}, 64'(cpu_hold), 64'd1);
    send_byte(n16[7:0], max_gap);
    send_byte(n16[15:8], max_gap);
    if (!ovf) begin
      for (int i = 0; i < n; i++) begin
        w = words[i];
        for (int k = 0; k < STEP; k++) begin
          c = c ^ w[8*k +: 8];
          send_byte(w[8*k +: 8], max_gap);
        end
      end
      send_byte(c ^ chk_xor, max_gap);
    end
    in_valid = 1'b0;
    check({name, ":hold_in_final"}, 64'(cpu_hold), 64'd1);
    @(negedge clk);
    ok = !ovf && (chk_xor == 8'h00);
    nw = ovf ? 0 : n;
    check({name, ":done"}, 64'(done), 64'(ok));
    check({name, ":err"}, 64'(err), 64'(!ok));
    check({name, ":hold_released"}, 64'(cpu_hold), 64'd0);
    check({name, ":ready_idle"}, 64'(in_ready), 64'd1);
    check({name, ":write_count"}, 64'(got_addr.size()), 64'(nw));
    check({name, ":ready_in_write"}, 64'(rdy_in_write), 64'd0);
    for (int i = 0; i < nw && i < got_addr.size(); i++) begin
      check({name, ":addr"}, 64'(got_addr[i]), 64'(i));
      check({name, ":data"}, 64'(got_data[i]), 64'(words[i]));
    end
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  gb;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst:pgm", 64'(pgm), 64'd0);
    check("rst:addr", 64'(addr), 64'd0);
    check("rst:data", 64'(data), 64'd0);
    check("rst:hold", 64'(cpu_hold), 64'd0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:err", 64'(err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst:ready", 64'(in_ready), 64'd1);

    // Two-word directed load
    words = '{32'h00500013, 32'h00A00093};
    run_frame("t1", 2, 8'h00, 0);

    // Zero-count frames, good and bad checksum
    words.delete();
    run_frame("t2_ok", 0, 8'h00, 0);
    run_frame("t2_bad", 0, 8'h01, 0);

    // Corrupted checksum still writes, next good frame recovers
    fill_random(1);
    run_frame("t3_bad", 1, 8'h40, 0);
    run_frame("t3_ok", 1, 8'h00, 0);

    // Count overflow and the largest legal count
    run_frame("t4_ovf", MAXN + 1, 8'h00, 0);
    fill_random(MAXN);
    run_frame("t4_max", MAXN, 8'h00, 0);

    // Same data gap-free and with random in_valid gaps; a SYNC-valued word is plain data
    fill_random(6);
    words[2] = 32'hA5A5A5A5;
    run_frame("t5_nogap", 6, 8'h00, 0);
    run_frame("t5_gaps", 6, 8'h00, 3);

    // Asynchronous reset in the middle of the data field
    fill_random(4);
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int j = 0; j < 6; j++) begin
      w = words[j / STEP];
      send_byte(w[8*(j % STEP) +: 8], 0);
    end
    #3;
    rst = 1'b1;
    #1;
    check("t6:pgm", 64'(pgm), 64'd0);
    check("t6:addr", 64'(addr), 64'd0);
    check("t6:data", 64'(data), 64'd0);
    check("t6:hold", 64'(cpu_hold), 64'd0);
    check("t6:done", 64'(done), 64'd0);
    check("t6:err", 64'(err), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6:ready", 64'(in_ready), 64'd1);
    got_addr.delete();
    got_data.delete();
    for (int j = 0; j < 5; j++) begin
      gb = 8'($urandom);
      if (gb == 8'hA5) gb = 8'h5A;
      send_byte(gb, 1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t6:garbage_writes", 64'(got_addr.size()), 64'd0);
    check("t6:garbage_hold", 64'(cpu_hold), 64'd0);
    run_frame("t6_fresh", 4, 8'h00, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Byte-stream boot loader that sequences writes into the instruction memory through its programming port (pgm/addr/data).
- Accepts a framed byte stream from a UART/debug bridge over a valid/ready handshake.
- Assembles STEP-byte little-endian instruction words and issues one single-cycle write per word, from word address 0 upward.
- Holds the CPU while loading and reports done/err.

Parameters:
INSTR_ADDR_WIDTH, 20, instruction memory word-address width; must match the instruction memory instance
STEP, 4, bytes per instruction word; data width = STEP*8
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data holds a byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
pgm  output  1  instruction-memory write strobe, one cycle per word
addr  output  INSTR_ADDR_WIDTH  word address for the write
data  output  STEP*8  assembled word for the write
cpu_hold  output  1  stall/hold the core while high
done  output  1  sticky: last frame loaded and checksum OK
err  output  1  sticky: last frame aborted (bad checksum or count overflow)

Behaviour:
- Byte accepted on a rising clk edge with in_valid && in_ready. No byte is consumed otherwise.
- Frame format: SYNC_BYTE, CNT_LO, CNT_HI (16-bit word count N, little-endian), N*STEP data bytes, CHK.
  - CHK = XOR of all data bytes.
  - Byte k of a word (k = 0..STEP-1) lands in data[8k+7:8k].
- States:
  - IDLE: in_ready=1. Non-SYNC bytes are discarded. On SYNC: clear done/err, set cpu_hold=1, go to CNT_L.
  - CNT_L: in_ready=1. Latch the low count byte, go to CNT_H.
  - CNT_H: in_ready=1. Latch the high count byte; addr<=0, checksum<=0, byte index<=0.
    - N > 2**INSTR_ADDR_WIDTH -> ERR.
    - N == 0 -> CHECK.
    - Otherwise -> DATA.
  - DATA: in_ready=1. Shift the byte into the word register, XOR it into the checksum, increment the byte index. After the STEP-th byte -> WRITE.
  - WRITE: in_ready=0, pgm=1 for exactly this one cycle. addr = current word index, data = assembled word. Next cycle: addr+1, remaining count-1; remaining==0 -> CHECK, else DATA (byte index 0).
  - CHECK: in_ready=1. Compare the received byte with the checksum. Equal -> DONE, else ERR.
  - DONE: done<=1, cpu_hold<=0, go to IDLE in the same transition (DONE is a one-cycle state with in_ready=0).
  - ERR: err<=1, cpu_hold<=0, then IDLE (one cycle, in_ready=0).
- Write latency: pgm asserts the cycle after the STEP-th data byte is accepted. Words already written are not rolled back on error.
- cpu_hold is high from the cycle after SYNC is accepted until the cycle after DONE/ERR.
- A SYNC value inside the count, data or CHK fields is treated as ordinary data, not a restart.
- addr never wraps: the overflow check guarantees the last write address is at most 2**INSTR_ADDR_WIDTH-1.
- in_valid gaps or in_valid held low: the FSM waits with no timeout and all outputs stable.
- Outputs pgm, in_ready and cpu_hold decode from registered state; addr/data/done/err are registers.
- Reset (asynchronous, any time, including mid-frame): state=IDLE, pgm=0, addr=0, data=0, cpu_hold=0, done=0, err=0, counters/checksum=0. in_ready=1 after reset release. A partially loaded frame is abandoned.

Test Plan:
1. Two-word load, STEP=4, stream A5 02 00 13 00 50 00 93 00 A0 00 CHK=XOR(all 8 data bytes) -> pgm pulses twice: addr=0 data=0x00500013, then addr=1 data=0x00A00093. done=1, err=0, cpu_hold falls after CHK.
2. Zero count A5 00 00 00 -> no pgm pulse, done=1. Same with CHK=01 -> err=1, done=0.
3. Corrupted checksum on a one-word frame -> one pgm write at addr 0 still occurs, err=1, done=0. A following valid frame clears err and sets done.
4. INSTR_ADDR_WIDTH=5, count 0x0021 (33) -> ERR right after CNT_HI, no pgm pulse, err=1. Count 0x0020 loads words 0..31 with the last write at addr=31.
5. Backpressure/gaps: random in_valid idle cycles, plus in_valid held high through WRITE -> in_ready=0 in WRITE, no byte lost or duplicated, written data identical to the gap-free run.
6. rst asserted asynchronously mid-DATA (between clock edges) -> all outputs zero immediately, cpu_hold=0. Garbage bytes then a fresh frame -> garbage discarded, fresh frame loads correctly.
